// File: rtl/pulse_delay_pkg.sv
// pulse_delay_pkg: shared types and helpers
// for the multi-channel pulse delay line.
package pulse_delay_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_t;

  // A delay is usable when it lies in 1..dmax.
  function automatic bit delay_valid(
    input logic [31:0] d,
    input logic [31:0] dmax
  );
    return (d != 32'd0) && (d <= dmax);
  endfunction

endpackage

// File: rtl/pulse_delay_line_if.sv
// pulse_delay_line_if: control, config and
// pulse bundle between DAQ logic and delay line.
interface pulse_delay_line_if
  import pulse_delay_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int DELAY_W  = 7
);

  logic                enable;
  logic [DELAY_W-1:0]  delay_cfg;
  logic                delay_load;
  logic [CHANNELS-1:0] ch_mask;
  logic [CHANNELS-1:0] pulse_in;
  logic [CHANNELS-1:0] pulse_out;
  logic                filling;
  logic                running;
  logic                cfg_err;
  logic [DELAY_W-1:0]  active_delay;

  modport master (
    output enable,
    output delay_cfg,
    output delay_load,
    output ch_mask,
    output pulse_in,
    input  pulse_out,
    input  filling,
    input  running,
    input  cfg_err,
    input  active_delay
  );

  modport slave (
    input  enable,
    input  delay_cfg,
    input  delay_load,
    input  ch_mask,
    input  pulse_in,
    output pulse_out,
    output filling,
    output running,
    output cfg_err,
    output active_delay
  );

endinterface

// File: rtl/pulse_delay_ram.sv
// pulse_delay_ram: simple dual-port buffer,
// synchronous write, registered read.
module pulse_delay_ram
  import pulse_delay_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read; old data on a same-address write
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pulse_delay_line.sv
// pulse_delay_line: replays each pulse channel
// exactly active_delay cycles later.
module pulse_delay_line
  import pulse_delay_pkg::*;
#(
  parameter int CHANNELS      = 16,
  parameter int MAX_DELAY     = 64,
  parameter int DEFAULT_DELAY = 50,
  parameter int DELAY_W       = $clog2(MAX_DELAY + 1),
  parameter logic [CHANNELS-1:0] INPUT_INVERT =
    {CHANNELS{1'b1}}
) (
  input logic clk,
  input logic rst,
  pulse_delay_line_if.slave bus
);

  localparam int AW =
    (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int SW = DELAY_W + 1;

  state_t              state;
  state_t              state_n;
  logic                restart;
  logic                load_ok;
  logic                we;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       wr_ptr_n;
  logic [AW-1:0]       wr_addr;
  logic [AW-1:0]       rd_addr;
  logic [SW-1:0]       rd_sum;
  logic [DELAY_W-1:0]  fill_cnt;
  logic [DELAY_W-1:0]  fill_cnt_n;
  logic [DELAY_W-1:0]  delay_q;
  logic                err_q;
  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] din_q;
  logic [CHANNELS-1:0] ram_q;
  logic [CHANNELS-1:0] rd_data;
  logic [CHANNELS-1:0] out_n;
  logic [CHANNELS-1:0] out_q;

  assign din = bus.pulse_in ^ INPUT_INVERT;
  assign load_ok = bus.delay_load &&
    delay_valid(32'(bus.delay_cfg),
                32'(MAX_DELAY));

  assign bus.pulse_out    = out_q;
  assign bus.filling      = (state == FILL);
  assign bus.running      = (state == RUN);
  assign bus.cfg_err      = err_q;
  assign bus.active_delay = delay_q;

  // next state; a valid reload restarts the fill
  always_comb begin
    state_n = state;
    restart = 1'b0;
    unique case (state)
      IDLE: begin
        state_n = FILL;
        restart = 1'b1;
      end
      FILL: begin
        if (load_ok) restart = 1'b1;
        else if (fill_cnt == delay_q)
          state_n = RUN;
      end
      RUN: begin
        if (load_ok) begin
          state_n = FILL;
          restart = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!bus.enable) begin
      state_n = IDLE;
      restart = 1'b0;
    end
  end

  // pointers, read address and output data
  always_comb begin
    we         = (state_n != IDLE);
    wr_addr    = restart ? '0 : wr_ptr;
    wr_ptr_n   = '0;
    fill_cnt_n = '0;
    if (we) begin
      wr_ptr_n = (wr_addr == AW'(MAX_DELAY - 1))
        ? '0 : wr_addr + 1'b1;
      if (restart)
        fill_cnt_n = DELAY_W'(1);
      else if (state_n == FILL)
        fill_cnt_n = fill_cnt + 1'b1;
      else
        fill_cnt_n = fill_cnt;
    end
    // read one cycle early: slot written D-1 ago
    rd_sum = SW'(wr_ptr) + SW'(MAX_DELAY + 1)
           - SW'(delay_q);
    if (rd_sum >= SW'(MAX_DELAY))
      rd_sum = rd_sum - SW'(MAX_DELAY);
    rd_addr = AW'(rd_sum);
    // D=1 cannot go through the RAM read register
    rd_data = (delay_q == DELAY_W'(1))
      ? din_q : ram_q;
    out_n = (state_n == RUN)
      ? (rd_data & bus.ch_mask) : '0;
  end

  // state, pointers and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      out_q    <= '0;
      din_q    <= '0;
    end else begin
      state    <= state_n;
      wr_ptr   <= wr_ptr_n;
      fill_cnt <= fill_cnt_n;
      out_q    <= out_n;
      din_q    <= din;
    end
  end

  // delay configuration and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_q <= DELAY_W'(DEFAULT_DELAY);
      err_q   <= 1'b0;
    end else if (bus.delay_load) begin
      if (load_ok) begin
        delay_q <= bus.delay_cfg;
        err_q   <= 1'b0;
      end else begin
        err_q   <= 1'b1;
      end
    end
  end

  pulse_delay_ram #(
    .WIDTH (CHANNELS),
    .DEPTH (MAX_DELAY),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_addr),
    .wdata (din),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_pulse_delay_line.sv
// tb_pulse_delay_line: directed checks of the
// delay line, plain and input-inverting copies.
module tb_pulse_delay_line;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pulse_delay_line_if #(
    .CHANNELS (16),
    .DELAY_W  (7)
  ) b ();

  pulse_delay_line_if #(
    .CHANNELS (16),
    .DELAY_W  (7)
  ) bi ();

  // inverting copy sees complemented inputs, so
  // its outputs must match the plain copy
  assign bi.enable     = b.enable;
  assign bi.delay_cfg  = b.delay_cfg;
  assign bi.delay_load = b.delay_load;
  assign bi.ch_mask    = b.ch_mask;
  assign bi.pulse_in   = ~b.pulse_in;

  pulse_delay_line #(
    .INPUT_INVERT (16'h0000)
  ) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  pulse_delay_line u1 (
    .clk (clk),
    .rst (rst),
    .bus (bi)
  );

  int cyc = 0;
  logic [15:0] hist [0:8191];

  // record the raw input sampled at each edge
  always @(posedge clk) begin
    hist[cyc] <= b.pulse_in;
    cyc <= cyc + 1;
  end

  int total = 0;
  int passed = 0;

  int md = 50;
  int mr = 0;
  bit err = 1'b0;
  bit idle = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] v0();
    return {b.cfg_err, b.active_delay,
            b.running, b.filling, b.pulse_out};
  endfunction

  function automatic logic [25:0] v1();
    return {bi.cfg_err, bi.active_delay,
            bi.running, bi.filling, bi.pulse_out};
  endfunction

  task automatic chk(
    input string tag,
    input logic [25:0] obs,
    input logic [25:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else begin
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  // n cycles; optional load on first cycle;
  // rnd=0 drives all-low inputs
  task automatic stream(
    input string tag,
    input int n,
    input int ldv,
    input bit rnd
  );
    int e;
    int k;
    bit ld;
    bit vld;
    logic [25:0] exp;
    for (int i = 0; i < n; i++) begin
      ld = (ldv >= 0) && (i == 0);
      b.pulse_in   = rnd ? 16'($urandom) : 16'h0;
      b.delay_load = ld;
      b.delay_cfg  = ld ? 7'(ldv) : 7'd0;
      tick();
      b.delay_load = 1'b0;
      e = cyc - 1;
      vld = ld && (ldv >= 1) && (ldv <= 64);
      if (rst) begin
        md = 50;
        err = 1'b0;
        idle = 1'b1;
      end else begin
        if (ld) begin
          if (vld) begin
            md = ldv;
            err = 1'b0;
          end else begin
            err = 1'b1;
          end
        end
        if (!b.enable) begin
          idle = 1'b1;
        end else if (idle || vld) begin
          idle = 1'b0;
          mr = e;
        end
      end
      k = e - mr;
      if (rst || idle)
        exp = {err, 7'(md), 2'b00, 16'h0};
      else if (k < md)
        exp = {err, 7'(md), 2'b01, 16'h0};
      else
        exp = {err, 7'(md), 2'b10,
               hist[e - md] & b.ch_mask};
      chk($sformatf("%s@%0d", tag, e), v0(), exp);
      chk($sformatf("%s_inv@%0d", tag, e),
          v1(), exp);
    end
  endtask

  initial begin
    int e0;
    logic [25:0] exp;
    rst = 1'b1;
    b.enable = 1'b0;
    b.delay_load = 1'b0;
    b.delay_cfg = 7'd0;
    b.ch_mask = 16'hFFFF;
    b.pulse_in = 16'h0;

    stream("reset", 3, -1, 1'b1);
    rst = 1'b0;
    stream("idle", 2, -1, 1'b1);

    // single pulse on ch0, ten edges after enable
    b.enable = 1'b1;
    e0 = 0;
    for (int k = 0; k <= 70; k++) begin
      b.pulse_in = (k == 10) ? 16'h0001 : 16'h0000;
      tick();
      if (k == 0) e0 = cyc - 1;
      exp = {1'b0, 7'd50, (k >= 50), (k < 50),
             (k == 60) ? 16'h0001 : 16'h0000};
      chk($sformatf("pulse k=%0d", k), v0(), exp);
      chk($sformatf("pulse_inv k=%0d", k),
          v1(), exp);
    end
    idle = 1'b0;
    mr = e0;
    md = 50;
    stream("run50", 20, -1, 1'b1);

    // minimum and maximum delay with wrap
    stream("d1", 500, 1, 1'b1);
    stream("d64", 1000, 64, 1'b1);

    // reload mid-run: no stale data
    stream("d50", 120, 50, 1'b1);
    stream("d20", 100, 20, 1'b1);

    // invalid loads leave the stream alone
    stream("d50b", 60, 50, 1'b1);
    stream("bad0", 20, 0, 1'b1);
    stream("bad65", 20, 65, 1'b1);
    stream("d30", 60, 30, 1'b1);

    // masking, then live mask change
    b.ch_mask = 16'h00FF;
    stream("mask", 60, -1, 1'b1);
    b.ch_mask = 16'hFFFF;
    stream("unmask", 10, -1, 1'b1);
    stream("quiet", 40, -1, 1'b0);

    // enable drop and re-assert
    b.enable = 1'b0;
    stream("off", 5, -1, 1'b1);
    b.enable = 1'b1;
    stream("on", 40, -1, 1'b1);

    // load while disabled; load on start edge
    b.enable = 1'b0;
    stream("offld", 3, 12, 1'b1);
    b.enable = 1'b1;
    stream("startld", 20, 8, 1'b1);

    // reset in the middle of a fill
    stream("d40", 10, 40, 1'b1);
    rst = 1'b1;
    stream("rstfill", 2, -1, 1'b1);
    rst = 1'b0;
    stream("refill", 60, -1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
